// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - fetch/data arbiter in front of a single-port synchronous-read memory
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of fixed data-port priority.
module mem_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]  state;
    logic        cap_dm;
    logic        cap_we;
    logic [15:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        pick_dm;

`ifdef MEM_ARB_RR_EN
    logic last_dm;

    // On a tie the port that was not granted most recently wins.
    assign pick_dm = dm_req & (~if_req | ~last_dm);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dm <= 1'b1;
        end else if (state == ISSUE) begin
            last_dm <= cap_dm;
        end
    end
`else
    assign pick_dm = dm_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap_dm    <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= 16'd0;
            cap_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            dm_rdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req | dm_req) begin
                        state     <= ISSUE;
                        cap_dm    <= pick_dm;
                        cap_we    <= pick_dm & dm_we;
                        cap_addr  <= pick_dm ? dm_addr : if_addr;
                        cap_wdata <= pick_dm ? dm_wdata : 32'd0;
                    end
                end
                ISSUE: begin
                    state <= cap_we ? IDLE : RESP;
                end
                RESP: begin
                    // Memory word arrives during RESP; the owning port's register holds it afterwards.
                    state <= IDLE;
                    if (cap_dm) begin
                        dm_rdata <= mem_rdata;
                    end else begin
                        if_rdata <= mem_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = (state == ISSUE) & cap_we;
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;
    assign if_gnt    = (state == ISSUE) & ~cap_dm;
    assign dm_gnt    = (state == ISSUE) & cap_dm;
    assign if_rvalid = (state == RESP) & ~cap_dm;
    assign dm_rvalid = (state == RESP) & cap_dm;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed plus randomized bench for mem_arb against a transaction-level model
`timescale 1ns/1ps
module tb_mem_arb;
    localparam int NC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'd0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = 16'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arb dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-port memory with synchronous read.
    logic [31:0] tb_mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) tb_mem[i] = 32'd0;
        tb_mem[16'h0010] = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) tb_mem[mem_addr] = mem_wdata;
            else if (mem_en) mem_rdata <= tb_mem[mem_addr];
        end
    end

    // Reference model: each access is a scheduled set of events in absolute cycle slots.
    logic [31:0] ref_mem [0:65535];
    int cyc = 0;
    int free_at = 0;
    bit          e_if_gnt [NC], e_dm_gnt [NC], e_en [NC], e_we [NC];
    bit          e_if_rv [NC], e_dm_rv [NC], e_if_up [NC], e_dm_up [NC];
    logic [15:0] e_addr [NC];
    logic [31:0] e_wdata [NC], e_up_val [NC];
    bit          x_if_gnt, x_dm_gnt, x_en, x_we, x_if_rv, x_dm_rv, x_busy;
    logic [15:0] x_addr;
    logic [31:0] x_wdata;
    logic [31:0] x_if_rdata = 32'd0;
    logic [31:0] x_dm_rdata = 32'd0;

    initial begin
        bit win_dm, tie_dm, last_dm;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 32'd0;
        ref_mem[16'h0010] = 32'hDEADBEEF;
        last_dm = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                for (int i = cyc; i < cyc + 4 && i < NC; i++) begin
                    e_if_gnt[i] = 0; e_dm_gnt[i] = 0; e_en[i] = 0; e_we[i] = 0;
                    e_if_rv[i] = 0; e_dm_rv[i] = 0; e_if_up[i] = 0; e_dm_up[i] = 0;
                end
                free_at = cyc;
                x_if_rdata = 32'd0;
                x_dm_rdata = 32'd0;
                last_dm = 1'b1;
            end else if (cyc - 1 >= free_at && (if_req || dm_req) && cyc + 2 < NC) begin
`ifdef MEM_ARB_RR_EN
                tie_dm = !last_dm;
`else
                tie_dm = 1'b1;
`endif
                win_dm = dm_req && (!if_req || tie_dm);
                last_dm = win_dm;
                a = win_dm ? dm_addr : if_addr;
                e_en[cyc] = 1;
                e_addr[cyc] = a;
                if (win_dm) e_dm_gnt[cyc] = 1; else e_if_gnt[cyc] = 1;
                if (win_dm && dm_we) begin
                    e_we[cyc] = 1;
                    e_wdata[cyc] = dm_wdata;
                    ref_mem[a] = dm_wdata;
                    free_at = cyc + 1;
                end else begin
                    if (win_dm) begin
                        e_dm_rv[cyc + 1] = 1;
                        e_dm_up[cyc + 2] = 1;
                    end else begin
                        e_if_rv[cyc + 1] = 1;
                        e_if_up[cyc + 2] = 1;
                    end
                    e_up_val[cyc + 2] = ref_mem[a];
                    free_at = cyc + 2;
                end
            end
            if (cyc < NC) begin
                if (e_if_up[cyc]) x_if_rdata = e_up_val[cyc];
                if (e_dm_up[cyc]) x_dm_rdata = e_up_val[cyc];
                x_if_gnt = e_if_gnt[cyc]; x_dm_gnt = e_dm_gnt[cyc];
                x_en = e_en[cyc]; x_we = e_we[cyc];
                x_addr = e_addr[cyc]; x_wdata = e_wdata[cyc];
                x_if_rv = e_if_rv[cyc]; x_dm_rv = e_dm_rv[cyc];
            end
            x_busy = (cyc < free_at);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("if_gnt", if_gnt, x_if_gnt);
                chk("dm_gnt", dm_gnt, x_dm_gnt);
                chk("mem_en", mem_en, x_en);
                chk("mem_we", mem_we, x_we);
                chk("if_rvalid", if_rvalid, x_if_rv);
                chk("dm_rvalid", dm_rvalid, x_dm_rv);
                chk("busy", busy, x_busy);
                chk("if_rdata", if_rdata, x_if_rdata);
                chk("dm_rdata", dm_rdata, x_dm_rdata);
                if (x_en) chk("mem_addr", mem_addr, x_addr);
                if (x_we) chk("mem_wdata", mem_wdata, x_wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks %0d", n_checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] r;
        r = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
        return r;
    endfunction

    initial begin
        int ng;
        bit seen;
        tick(); tick();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);

        // Fetch of a preloaded word.
        rst = 0; if_req = 1; if_addr = 16'h0010;
        tick();
        chk("f_if_gnt", if_gnt, 1);
        chk("f_mem_en", mem_en, 1);
        chk("f_mem_we", mem_we, 0);
        chk("f_mem_addr", mem_addr, 16'h0010);
        chk("model_if_gnt", x_if_gnt, 1);
        if_req = 0;
        tick();
        chk("f_if_rvalid", if_rvalid, 1);
        tick();
        chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("model_if_rdata", x_if_rdata, 32'hDEADBEEF);
        chk("f_busy_done", busy, 0);

        // Data write then fetch of the same word.
        dm_req = 1; dm_we = 1; dm_addr = 16'h0100; dm_wdata = 32'h12345678;
        tick();
        chk("w_dm_gnt", dm_gnt, 1);
        chk("w_mem_we", mem_we, 1);
        chk("w_mem_wdata", mem_wdata, 32'h12345678);
        dm_req = 0; dm_we = 0;
        tick();
        chk("w_no_rvalid", dm_rvalid, 0);
        chk("w_busy_low", busy, 0);
        if_req = 1; if_addr = 16'h0100;
        tick(); if_req = 0;
        tick(); tick();
        chk("w_readback", if_rdata, 32'h12345678);

`ifndef MEM_ARB_RR_EN
        // Simultaneous requests: data port first.
        if_req = 1; if_addr = 16'h0010; dm_req = 1; dm_we = 0; dm_addr = 16'h0100;
        tick();
        chk("t_dm_gnt1", dm_gnt, 1);
        chk("t_if_gnt1", if_gnt, 0);
        dm_req = 0;
        tick();
        chk("t_dm_rv2", dm_rvalid, 1);
        tick();
        chk("t_if_gnt3", if_gnt, 0);
        chk("t_dm_rdata3", dm_rdata, 32'h12345678);
        tick();
        chk("t_if_gnt4", if_gnt, 1);
        if_req = 0;
        tick();
        chk("t_if_rv5", if_rvalid, 1);
        tick();
`else
        // Continuous contention alternates, starting with fetch after reset.
        rst = 1; tick(); rst = 0;
        if_req = 1; if_addr = 16'h0010; dm_req = 1; dm_we = 0; dm_addr = 16'h0100;
        ng = 0;
        for (int k = 0; k < 30 && ng < 4; k++) begin
            tick();
            if (if_gnt || dm_gnt) begin
                chk("rr_order_dm", dm_gnt, 32'(ng % 2));
                ng++;
            end
        end
        chk("rr_grants", 32'(ng), 4);
        if_req = 0; dm_req = 0;
        tick(); tick(); tick();
`endif

        // Reset during the response cycle of a fetch.
        if_req = 1; if_addr = 16'h0010;
        tick(); if_req = 0;
        tick(); rst = 1;
        tick(); rst = 0;
        chk("r_if_rvalid", if_rvalid, 0);
        chk("r_busy", busy, 0);
        chk("r_mem_en", mem_en, 0);
        chk("r_if_rdata", if_rdata, 0);

        // Write request coincident with reset is never issued.
        dm_req = 1; dm_we = 1; dm_addr = 16'h0010; dm_wdata = 32'hBAD0BAD0; rst = 1;
        tick();
        chk("rw_mem_en", mem_en, 0);
        chk("rw_dm_gnt", dm_gnt, 0);
        rst = 0; dm_req = 0; dm_we = 0;
        if_req = 1; if_addr = 16'h0010;
        tick(); if_req = 0;
        tick(); tick();
        chk("rw_mem_intact", if_rdata, 32'hDEADBEEF);

`ifndef MEM_ARB_RR_EN
        // Back-to-back data writes starve fetch until data drops.
        if_req = 1; if_addr = 16'hFFFF;
        dm_req = 1; dm_we = 1; dm_addr = 16'h0020; dm_wdata = $urandom;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("starve_if_gnt", if_gnt, 0);
            if (dm_gnt) begin
                dm_addr = 16'h0020 + 16'(i);
                dm_wdata = $urandom;
            end
        end
        dm_req = 0; dm_we = 0;
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            if (if_gnt) seen = 1;
        end
        chk("if_gnt_after_drop", 32'(seen), 1);
        if_req = 0;
        tick(); tick(); tick();
`endif

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (!if_req || if_gnt) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = rand_addr();
            end
            if (!dm_req || dm_gnt) begin
                dm_req = ($urandom_range(0, 2) != 0);
                dm_we = $urandom_range(0, 1) == 1;
                dm_addr = rand_addr();
                dm_wdata = $urandom;
            end
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 0; if_req = 0; dm_req = 0;
        tick(); tick(); tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
